// File: rtl/seg_scan_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// seg_pkg
//   Shared definitions for the 7-segment scan controller.
//   SEG_OFF        : active-low segment pattern with every segment dark
//   MAX_DIGITS     : widest display the helpers are sized for
//   an_onehot_low  : active-low one-hot anode vector for a digit index
//   lz_blank       : leading-zero test for digit k of a (zero-padded) value
// ---------------------------------------------------------------------------
package seg_pkg;

    localparam logic [6:0]  SEG_OFF    = 7'h7F;
    localparam int unsigned MAX_DIGITS = 8;
    localparam int unsigned MAX_W      = 4 * MAX_DIGITS;

    // Result is MAX_DIGITS wide; callers keep the low NUM_DIGITS bits.
    function automatic logic [MAX_DIGITS-1:0] an_onehot_low(input logic [2:0] idx);
        return ~(8'b1 << idx);
    endfunction

    // True when digit k is not the rightmost digit and it and every digit to
    // its left are zero. Unused upper nibbles are zero-padded by the caller,
    // so they never keep a digit lit.
    function automatic logic lz_blank(input logic [MAX_W-1:0] disp, input logic [2:0] k);
        logic nonzero;
        nonzero = 1'b0;
        for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
            if ((i >= 32'(k)) && (disp[4*i +: 4] != 4'h0)) begin
                nonzero = 1'b1;
            end
        end
        return (k != 3'd0) && !nonzero;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_dec7seg.sv
// ---------------------------------------------------------------------------
// dec7Seg
//   Hex nibble to common-anode 7-segment pattern (active-low).
//   in  [3:0] : hex digit 0..F
//   out [6:0] : segments {g,f,e,d,c,b,a}, 0 = segment lit
// ---------------------------------------------------------------------------
module dec7Seg
    import seg_pkg::*;
(
    input  logic [3:0] in,
    output logic [6:0] out
);

    always_comb begin
        out = SEG_OFF;
        case (in)
            4'h0: out = 7'h40;
            4'h1: out = 7'h79;
            4'h2: out = 7'h24;
            4'h3: out = 7'h30;
            4'h4: out = 7'h19;
            4'h5: out = 7'h12;
            4'h6: out = 7'h02;
            4'h7: out = 7'h78;
            4'h8: out = 7'h00;
            4'h9: out = 7'h10;
            4'hA: out = 7'h08;
            4'hB: out = 7'h03;
            4'hC: out = 7'h46;
            4'hD: out = 7'h21;
            4'hE: out = 7'h06;
            4'hF: out = 7'h0E;
            default: out = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl
//   Time-multiplexed scan controller for a multi-digit common-anode
//   7-segment display. A new value is taken into a shadow buffer through a
//   valid/ready port and copied to the display register only when the scan
//   wraps back to digit 0, so a frame never mixes old and new digits.
//
//   Parameters
//     NUM_DIGITS  : digits scanned (2..8)
//     REFRESH_DIV : clk cycles each digit stays lit (>= 1)
//   Ports
//     clk         : system clock, rising edge
//     rst         : synchronous active-high reset
//     load_valid  : load_data valid this cycle
//     load_data   : packed nibbles, nibble k = digit k, digit 0 rightmost
//     load_ready  : shadow buffer can accept a load
//     lz_en       : leading-zero blanking enable, sampled every cycle
//     an          : anode enables, active-low one-hot
//     seg         : segment pattern, active-low, 7'h7F = all off
//     frame_done  : one-cycle pulse after the scan wraps to digit 0
// ---------------------------------------------------------------------------
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load_valid,
    input  logic [4*NUM_DIGITS-1:0]   load_data,
    output logic                      load_ready,
    input  logic                      lz_en,
    output logic [NUM_DIGITS-1:0]     an,
    output logic [6:0]                seg,
    output logic                      frame_done
);

    localparam int unsigned CNT_W = $clog2(REFRESH_DIV + 1);
    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
    localparam int unsigned DW    = 4 * NUM_DIGITS;

    logic [CNT_W-1:0]      tick_cnt;
    logic [IDX_W-1:0]      idx;
    logic [DW-1:0]         disp;
    logic [DW-1:0]         shadow;
    logic                  pending;

    logic                  tick;
    logic                  last;
    logic                  wrap;
    logic                  xfer;
    logic [3:0]            nibble;
    logic [6:0]            dec_out;
    logic                  blank;
    logic [MAX_W-1:0]      disp_w;
    logic [MAX_DIGITS-1:0] an_full;
    logic [NUM_DIGITS-1:0] an_next;

    // ---------------- control decode ----------------
    always_comb begin
        tick       = (tick_cnt == CNT_W'(REFRESH_DIV - 1));
        last       = (idx == IDX_W'(NUM_DIGITS - 1));
        wrap       = tick & last;
        load_ready = ~pending & ~rst;
        xfer       = load_valid & load_ready;
    end

    // ---------------- digit datapath ----------------
    always_comb begin
        nibble = '0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                nibble = disp[4*k +: 4];
            end
        end
        disp_w  = MAX_W'(disp);
        blank   = lz_en & lz_blank(disp_w, 3'(idx));
        an_full = an_onehot_low(3'(idx));
        an_next = an_full[NUM_DIGITS-1:0];
    end

    dec7Seg u_dec (
        .in  (nibble),
        .out (dec_out)
    );

    // ---------------- state ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt   <= '0;
            idx        <= '0;
            disp       <= '0;
            shadow     <= '0;
            pending    <= 1'b0;
            an         <= '1;
            seg        <= SEG_OFF;
            frame_done <= 1'b0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            if (tick) begin
                idx <= last ? '0 : idx + 1'b1;
            end
            frame_done <= wrap;

            // A transfer needs pending=0 and a commit needs pending=1, so the
            // two branches never compete in the same cycle.
            if (xfer) begin
                shadow  <= load_data;
                pending <= 1'b1;
            end else if (wrap && pending) begin
                disp    <= shadow;
                pending <= 1'b0;
            end

            // Output stage shows the digit selected this cycle, one cycle
            // behind idx; disp is the pre-commit value on the wrap edge.
            an  <= an_next;
            seg <= blank ? SEG_OFF : dec_out;
        end
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for a multi-digit common-anode 7-segment display.
- Accepts a packed hex value through a valid/ready load port and holds it in a shadow buffer.
- Commits the shadow value to the display register only at frame boundaries, so no digit tears.
- Cycles one digit at a time through a single dec7Seg instance, driving registered anode-select and segment outputs to the board pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned; legal range 2..8
REFRESH_DIV, 100000, clk cycles each digit stays lit; legal range >= 1
CNT_W, $clog2(REFRESH_DIV+1), prescaler counter width; derived, not overridden

Ports:
clk  input  1  system clock; all state on the rising edge
rst  input  1  synchronous, active-high reset
load_valid  input  1  load_data is valid this cycle
load_data  input  4*NUM_DIGITS  packed nibbles; nibble k = digit k; digit 0 = least significant, rightmost
load_ready  output  1  shadow buffer can accept a load
lz_en  input  1  leading-zero blanking enable; sampled every cycle
an  output  NUM_DIGITS  anode enables, active-low, one-hot-low
seg  output  7  segment pattern from dec7Seg, active-low; 7'h7F = all off
frame_done  output  1  one-cycle pulse when the scan wraps from the last digit to digit 0

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values (first edge with rst=1):
  - tick_cnt=0, idx=0, disp=0, shadow=0, pending=0
  - an=all ones, seg=7'h7F, frame_done=0
  - load_ready=0 while rst=1
  - Any pending load is discarded.
- Prescaler:
  - tick_cnt counts 0..REFRESH_DIV-1, then wraps to 0.
  - tick is asserted in the cycle where tick_cnt==REFRESH_DIV-1.
  - REFRESH_DIV=1 gives a tick every cycle.
- Digit index:
  - idx advances on tick and wraps NUM_DIGITS-1 -> 0.
  - frame_done is registered: it is 1 in the cycle after the tick that wraps idx, and 0 otherwise.
- Load handshake:
  - load_ready = ~pending & ~rst (combinational).
  - A transfer occurs when load_valid & load_ready: shadow <= load_data and pending <= 1.
  - load_data is ignored when load_ready=0; the source holds its data.
- Commit:
  - On the wrapping tick with pending=1: disp <= shadow, pending <= 0.
  - A transfer cannot coincide with a commit, because pending=1 forces ready=0.
  - Latency from transfer to first visible digit is at most NUM_DIGITS*REFRESH_DIV+1 cycles.
- Output stage (registered, one cycle behind idx):
  - an <= all ones except bit idx = 0.
  - seg <= blank(idx) ? 7'h7F : dec7Seg(disp[4*idx +: 4]).
  - First edge after rst deasserts: an = {1..1,0} (digit 0), with seg for disp nibble 0.
- Leading-zero blanking: digit k is blanked when all of the following hold:
  - lz_en=1
  - k != 0
  - nibbles k..NUM_DIGITS-1 of disp are all zero
  Digit 0 is never blanked, so a value of 0 shows a single "0".
- No arithmetic beyond the counters; all counters are unsigned and wrap as stated.

Decomposition:
- Shared package seg_pkg holds:
  - SEG_OFF = 7'h7F
  - function an_onehot_low(idx) returning the active-low one-hot anode vector
  - lz_blank(disp, k) helper
- Sub-module: one instance of the existing dec7Seg (in[3:0] -> out[6:0]), fed by the nibble mux. No other sub-modules.

Test Plan:
- Prescaler and framing: NUM_DIGITS=4, REFRESH_DIV=4; reset, then free-run.
  - an steps 1110 -> 1101 -> 1011 -> 0111 -> 1110, changing exactly every 4 cycles.
  - frame_done is a single-cycle pulse every 16 cycles.
- Load/commit: after reset, load 16'h1234 with load_valid held one cycle.
  - load_ready drops next cycle.
  - seg stays dec7Seg(0) until the first frame_done.
  - Then digit0=dec7Seg(4), digit1=dec7Seg(3), digit2=dec7Seg(2), digit3=dec7Seg(1).
  - load_ready returns to 1.
- Backpressure: load 16'hABCF, then immediately hold load_valid with 16'h5555.
  - The second load is not taken until the commit of ABCF.
  - It is accepted in the first cycle ready=1 and displayed one frame later.
  - All hex digits A, B, C, F decode correctly.
- Leading-zero blanking: lz_en=1.
  - disp=16'h0070: digits 3 and 2 show seg=7'h7F, digit1 shows dec7Seg(7), digit0 shows dec7Seg(0).
  - disp=16'h0000: only digit0 is lit, showing dec7Seg(0).
  - lz_en=0: all four digits show dec7Seg(0).
- Reset mid-operation: assert rst for 1 cycle mid-frame with pending=1.
  - Next edge gives an=1111, seg=7'h7F, frame_done=0, load_ready=0.
  - After release: ready=1, disp=0, scan restarts at digit 0, and the old shadow value never appears.
- REFRESH_DIV=1 corner: the digit advances every cycle, frame_done pulses every NUM_DIGITS cycles, and the handshake still commits only on the wrap.
